// File: rtl/map_camera_ctrl.sv
// Camera sequencer for the map renderer: scrolls between floors on
// level requests, commits the floor, then flashes the map white.
module map_camera_ctrl #(
  parameter int CAMERA_WIDTH = 6,
  parameter int MAX_LEVEL    = 63,
  parameter int OFFSET_MAX   = 20,
  parameter int SCROLL_STEP  = 4,
  parameter int FLASH_FRAMES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic                    level_up_req,
  input  logic                    level_down_req,
  output logic [CAMERA_WIDTH-1:0] camera_y,
  output logic [CAMERA_WIDTH-1:0] camera_offset,
  output logic                    map_on,
  output logic                    busy,
  output logic                    req_ack,
  output logic                    level_done
);

  localparam int CW = CAMERA_WIDTH;
  localparam int FW =
    (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES + 1) : 1;

  localparam logic [FW-1:0] FLASH_INIT = FW'(FLASH_FRAMES);
  localparam logic [FW-1:0] FLASH_ONE  = FW'(1);
  localparam logic [CW-1:0] Y_MAX      = CW'(MAX_LEVEL);
  localparam logic [CW-1:0] Y_ONE      = CW'(1);
  localparam logic [CW-1:0] OFF_MAX    = CW'(OFFSET_MAX);
  localparam logic [CW-1:0] STEP       = CW'(SCROLL_STEP);
  localparam logic [CW:0]   OFF_MAX_W  = (CW+1)'(OFFSET_MAX);
  localparam logic [CW:0]   STEP_W     = (CW+1)'(SCROLL_STEP);

  typedef enum logic [1:0] {
    IDLE,
    SCROLL_UP,
    SCROLL_DOWN,
    FLASH
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] y_n, off_n;
  logic [FW-1:0] flash_cnt, cnt_n;
  logic          map_on_n, ack_n, done_n;
  logic          enter_flash;
  logic [CW:0]   up_sum;

  // One extra bit so the up-scroll sum cannot wrap.
  assign up_sum = {1'b0, camera_offset} + STEP_W;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      camera_y      <= '0;
      camera_offset <= '0;
      map_on        <= 1'b1;
      req_ack       <= 1'b0;
      level_done    <= 1'b0;
      flash_cnt     <= '0;
    end else begin
      state         <= state_n;
      camera_y      <= y_n;
      camera_offset <= off_n;
      map_on        <= map_on_n;
      req_ack       <= ack_n;
      level_done    <= done_n;
      flash_cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    y_n         = camera_y;
    off_n       = camera_offset;
    map_on_n    = map_on;
    cnt_n       = flash_cnt;
    ack_n       = 1'b0;
    done_n      = 1'b0;
    enter_flash = 1'b0;

    unique case (state)
      IDLE: begin
        unique case (1'b1)
          level_up_req && !level_down_req && camera_y < Y_MAX: begin
            state_n = SCROLL_UP;
            ack_n   = 1'b1;
          end
          level_down_req && !level_up_req && camera_y != '0: begin
            y_n     = camera_y - Y_ONE;
            off_n   = OFF_MAX;
            state_n = SCROLL_DOWN;
            ack_n   = 1'b1;
          end
          default: ;
        endcase
      end
      SCROLL_UP: begin
        if (frame_tick) begin
          if (up_sum >= OFF_MAX_W) begin
            y_n         = camera_y + Y_ONE;
            off_n       = '0;
            enter_flash = 1'b1;
          end else begin
            off_n = up_sum[CW-1:0];
          end
        end
      end
      SCROLL_DOWN: begin
        if (frame_tick) begin
          if (camera_offset <= STEP) begin
            off_n       = '0;
            enter_flash = 1'b1;
          end else begin
            off_n = camera_offset - STEP;
          end
        end
      end
      FLASH: begin
        if (frame_tick) begin
          cnt_n = flash_cnt - FLASH_ONE;
          if (flash_cnt == FLASH_ONE) begin
            map_on_n = 1'b1;
            state_n  = IDLE;
            done_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // With no flash configured the floor commit returns straight to idle.
    if (enter_flash) begin
      if (FLASH_FRAMES > 0) begin
        map_on_n = 1'b0;
        cnt_n    = FLASH_INIT;
        state_n  = FLASH;
      end else begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
  end

endmodule
